// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first,
// using one full-subtractor cell and a registered borrow, with valid/ready on both sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bw_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             bit_d;
  logic             bw_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell on the current LSBs; result bit enters from the MSB side.
  assign bit_d = sa_q[0] ^ sb_q[0] ^ bw_q;
  assign bw_d  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
  assign res_d = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));

  // in_ready is gated by its own register so the first edge after reset never accepts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      bw_q        <= 1'b0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            sa_q       <= a;
            sb_q       <= b;
            res_q      <= '0;
            bw_q       <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          bw_q  <= bw_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff_q      <= res_d;
            borrow_q    <= bw_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed cases
// and a 4-bit instance swept over every operand pair.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8_n, iv8, ir8, ov8, or8, bo8, busy8;
  logic [7:0] a8, b8, d8;
  logic       rst4_n, iv4, ir4, ov4, or4, bo4, busy4;
  logic [3:0] a4, b4, d4;

  int checks = 0;
  int errors = 0;

  logic [8:0]  q8[$];
  logic [12:0] q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow(bo8), .busy(busy8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(bo4), .busy(busy4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation: accept, check latency, hold under back-pressure, release.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int hold,
                     input bit noisy, input string nm);
    int k;
    logic [8:0] e;
    k = 0;
    while (!ir8 && k < 50) begin cyc(); k++; end
    checks++;
    if (ir8 !== 1'b1) begin
      errors++; $display("FAIL %s in_ready_timeout got=%b want=1", nm, ir8); return;
    end
    a8 = av; b8 = bv; iv8 = 1'b1;
    cyc();
    q8.push_back({(av < bv), 8'(av - bv)});
    iv8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || ir8 !== 1'b0) begin
      errors++; $display("FAIL %s accept busy=%b in_ready=%b want 1/0", nm, busy8, ir8);
    end
    k = 0;
    while (ov8 !== 1'b1 && k < 50) begin
      if (noisy) begin iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
      cyc(); k++;
    end
    checks++;
    if (k != 8) begin errors++; $display("FAIL %s latency got=%0d want=8", nm, k); end
    if (ov8 !== 1'b1) begin q8.delete(); iv8 = 1'b0; return; end
    e = q8.pop_front();
    checks++;
    if ({bo8, d8} !== e) begin
      errors++; $display("FAIL %s result got=%b/%h want=%b/%h", nm, bo8, d8, e[8], e[7:0]);
    end
    checks++;
    if (ir8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL %s done_flags in_ready=%b busy=%b want 0/0", nm, ir8, busy8);
    end
    for (int i = 0; i < hold; i++) begin
      if (noisy) begin iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
      or8 = 1'b0;
      cyc();
      checks++;
      if (ov8 !== 1'b1 || busy8 !== 1'b0 || {bo8, d8} !== e) begin
        errors++;
        $display("FAIL %s hold%0d ov=%b busy=%b got=%b/%h want 1/0/%b/%h",
                 nm, i, ov8, busy8, bo8, d8, e[8], e[7:0]);
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    cyc();
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++; $display("FAIL %s release ov=%b in_ready=%b busy=%b want 0/1/0", nm, ov8, ir8, busy8);
    end
    checks++;
    if ({bo8, d8} !== e) begin
      errors++; $display("FAIL %s kept got=%b/%h want=%b/%h", nm, bo8, d8, e[8], e[7:0]);
    end
  endtask

  task automatic test_reset();
    rst8_n = 1'b0; rst4_n = 1'b0;
    iv8 = 1'b1; a8 = 8'd5; b8 = 8'd3; or8 = 1'b0;
    iv4 = 1'b1; a4 = 4'd5; b4 = 4'd3; or4 = 1'b0;
    repeat (3) cyc();
    checks++;
    if (ov8 !== 1'b0 || d8 !== 8'd0 || bo8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8 ov=%b diff=%h borrow=%b busy=%b in_ready=%b want all 0", ov8, d8, bo8, busy8, ir8);
    end
    checks++;
    if (ov4 !== 1'b0 || d4 !== 4'd0 || bo4 !== 1'b0 || busy4 !== 1'b0 || ir4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4 ov=%b diff=%h borrow=%b busy=%b in_ready=%b want all 0", ov4, d4, bo4, busy4, ir4);
    end
    rst8_n = 1'b1; rst4_n = 1'b1;
    cyc();
    checks++;
    if (ir8 !== 1'b1 || busy8 !== 1'b0 || ir4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready8=%b busy8=%b in_ready4=%b busy4=%b want 1/0/1/0", ir8, busy8, ir4, busy4);
    end
    iv8 = 1'b0; iv4 = 1'b0;
  endtask

  task automatic test_basic();
    or8 = 1'b1;
    op8(8'd200, 8'd55, 0, 1'b0, "basic");
    op8(8'd77, 8'd0, 0, 1'b0, "b_zero");
    op8(8'd123, 8'd123, 0, 1'b0, "a_eq_b");
  endtask

  task automatic test_wrap();
    op8(8'd0, 8'd1, 0, 1'b0, "wrap");
    op8(8'd17, 8'd200, 0, 1'b0, "borrow");
  endtask

  task automatic test_back_to_back();
    op8(8'hA5, 8'h5A, 5, 1'b1, "backpressure");
    cyc();
    checks++;
    if (busy8 !== 1'b0 || ov8 !== 1'b0) begin
      errors++; $display("FAIL no_spurious_op busy=%b ov=%b want 0/0", busy8, ov8);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    op8(8'd1, 8'd2, 0, 1'b0, "pre_abort");
    a8 = 8'd100; b8 = 8'd3; iv8 = 1'b1;
    cyc();
    q8.push_back({1'b0, 8'd97});
    iv8 = 1'b0;
    repeat (4) cyc();
    checks++;
    if (busy8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++; $display("FAIL mid_run busy=%b ov=%b want 1/0", busy8, ov8);
    end
    rst8_n = 1'b0;
    repeat (2) cyc();
    q8.delete();
    checks++;
    if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b0 || d8 !== 8'd0 || bo8 !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset ov=%b busy=%b in_ready=%b diff=%h borrow=%b want 0", ov8, busy8, ir8, d8, bo8);
    end
    rst8_n = 1'b1;
    seen = 0;
    repeat (12) begin cyc(); if (ov8 === 1'b1 || busy8 === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_result cycles_active=%0d want=0", seen); end
    op8(8'd9, 8'd9, 0, 1'b0, "after_abort");
  endtask

  task automatic test_exhaustive();
    int k;
    bit done;
    logic v;
    logic [3:0] dd;
    logic bb;
    logic [12:0] e;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        iv4 = 1'b0;
        repeat ($urandom_range(0, 2)) cyc();
        k = 0;
        while (!ir4 && k < 50) begin cyc(); k++; end
        if (ir4 !== 1'b1) begin
          checks++; errors++; $display("FAIL exh_in_ready a=%0d b=%0d got=%b want=1", ia, ib, ir4);
          continue;
        end
        a4 = 4'(ia); b4 = 4'(ib); iv4 = 1'b1;
        cyc();
        q4.push_back({1'(ia < ib), 4'(ia - ib), 4'(ia), 4'(ib)});
        iv4 = 1'b0;
        done = 1'b0; k = 0;
        while (!done && k < 100) begin
          or4 = (k > 20) ? 1'b1 : 1'($urandom);
          v = ov4; dd = d4; bb = bo4;
          cyc(); k++;
          if (v && or4) done = 1'b1;
        end
        or4 = 1'b0;
        checks++;
        if (!done || q4.size() == 0) begin
          errors++; $display("FAIL exh_timeout a=%0d b=%0d done=%b", ia, ib, done);
          q4.delete();
          continue;
        end
        e = q4.pop_front();
        checks++;
        if (dd !== e[11:8]) begin
          errors++; $display("FAIL exh_diff a=%0d b=%0d got=%0d want=%0d", ia, ib, dd, e[11:8]);
        end
        checks++;
        if (bb !== e[12]) begin
          errors++; $display("FAIL exh_borrow a=%0d b=%0d got=%b want=%b", ia, ib, bb, e[12]);
        end
        checks++;
        if (4'(dd + e[3:0]) !== e[7:4]) begin
          errors++; $display("FAIL exh_readd a=%0d b=%0d diff+b=%0d want=%0d", ia, ib, 4'(dd + e[3:0]), e[7:4]);
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
